// File: rtl/regfile_mp.sv
// regfile_mp: parametrised 2-read/1-write register file with hardware clear sweep,
// hardwired zero register and optional same-cycle write-to-read bypass.
module regfile_mp #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = $clog2(DEPTH),
   parameter int ZERO_REG = DEPTH - 1,
   parameter int XP_REG   = DEPTH - 2,
   parameter bit BYPASS   = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [AW-1:0]    ra,
   input  logic [AW-1:0]    rb,
   input  logic [AW-1:0]    rc,
   input  logic             ra2sel,
   input  logic             wasel,
   input  logic             werf,
   input  logic [WIDTH-1:0] wdata,
   input  logic             clr,
   output logic [WIDTH-1:0] radata,
   output logic [WIDTH-1:0] rbdata,
   output logic             busy
);
   localparam logic [0:0] RUN = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;
   localparam logic [AW-1:0] ZR = AW'(ZERO_REG);
   localparam logic [AW-1:0] XP = AW'(XP_REG);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   logic [0:0] state;
   logic [AW-1:0] cnt;
   logic [AW-1:0] rb_addr;
   logic [AW-1:0] wa;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;
   logic clearing;
   logic we;
   logic [WIDTH-1:0] mem [DEPTH];
   assign clearing = state == CLEAR;
   assign busy = clearing;
   assign rb_addr = ra2sel ? rc : rb;
   assign wa = wasel ? XP : rc;
   assign we = !clearing && werf && wa != ZR;
   // a bypass hit on the zero register is masked by the zero check first
   always_comb begin
      rd_a = ra == ZR ? '0 : (BYPASS && werf && ra == wa) ? wdata : mem[ra];
      rd_b = rb_addr == ZR ? '0 : (BYPASS && werf && rb_addr == wa) ? wdata : mem[rb_addr];
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= CLEAR;
         cnt <= '0;
         radata <= '0;
         rbdata <= '0;
      end else if (clearing) begin
         radata <= '0;
         rbdata <= '0;
         cnt <= cnt + 1'b1;
         if (cnt == LAST) state <= RUN;
      end else begin
         radata <= rd_a;
         rbdata <= rd_b;
         if (clr) begin
            state <= CLEAR;
            cnt <= '0;
         end
      end
   end
   // storage has no reset; the sweep zeroes it one entry per cycle
   always_ff @(posedge clock) begin
      if (clearing) mem[cnt] <= '0;
      else if (we) mem[wa] <= wdata;
   end
endmodule
